// File: rtl/b_resp_tracker.sv
// ---------------------------------------------------------------------------
// b_resp_tracker
// Tracks outstanding AXI writes on the master side. Issued write IDs are
// queued in order. Each B response is checked against the oldest queued ID
// and its response code. The block then reports a one-cycle completion
// pulse, keeps a saturating error count, and raises a sticky watchdog
// timeout when a response is overdue.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_issue_valid/_id   write issued on AW/W, with its ID
//   o_issue_ready       tracker not full (combinational)
//   i_bvalid/o_bready   AXI B handshake (o_bready is registered)
//   i_bresp, i_bid      AXI B response code and ID
//   o_done_*            registered completion info, valid with o_done_valid
//   o_id_mismatch       pulses with o_done_valid when bid != expected ID
//   o_outstanding       number of writes awaiting a response
//   o_err_count         saturating count of failed completions
//   o_timeout           sticky watchdog flag
//   i_clear             clears o_err_count and o_timeout
// ---------------------------------------------------------------------------
module b_resp_tracker #(
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int CNT_W           = 8
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_issue_valid,
    input  logic [ID_W-1:0]                    i_issue_id,
    output logic                               o_issue_ready,
    input  logic                               i_bvalid,
    output logic                               o_bready,
    input  logic [1:0]                         i_bresp,
    input  logic [ID_W-1:0]                    i_bid,
    output logic                               o_done_valid,
    output logic [ID_W-1:0]                    o_done_id,
    output logic [1:0]                         o_done_resp,
    output logic                               o_done_ok,
    output logic                               o_id_mismatch,
    output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
    output logic [CNT_W-1:0]                   o_err_count,
    output logic                               o_timeout,
    input  logic                               i_clear
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OCC_W = PTR_W + 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);

    logic [ID_W-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_outstanding;
    logic             r_bready;
    logic             r_done_valid;
    logic [ID_W-1:0]  r_done_id;
    logic [1:0]       r_done_resp;
    logic             r_done_ok;
    logic             r_id_mismatch;
    logic [CNT_W-1:0] r_err_count;
    logic [WD_W-1:0]  r_wd_cnt;
    logic             r_timeout;

    logic             w_issue_ready;
    logic             w_push;
    logic             w_pop;
    logic [ID_W-1:0]  w_head;
    logic             w_mismatch;
    logic             w_resp_ok;
    logic             w_err_sat;
    logic             w_stall;
    logic [OCC_W-1:0] w_outstanding_next;
    logic [WD_W-1:0]  w_wd_next;
    logic             w_timeout_hit;

    // A refused issue while full is silently dropped.
    assign w_issue_ready = (r_outstanding != OCC_FULL);
    // r_bready mirrors (r_outstanding != 0), so a pop never hits an empty FIFO.
    assign w_push        = i_issue_valid && w_issue_ready;
    assign w_pop         = i_bvalid && r_bready;
    assign w_head        = r_fifo[r_rd_ptr];
    assign w_mismatch    = (i_bid != w_head);
    assign w_resp_ok     = (i_bresp[1] == 1'b0) && !w_mismatch;
    assign w_err_sat     = (r_err_count == {CNT_W{1'b1}});
    assign w_stall       = (r_outstanding != {OCC_W{1'b0}}) && !w_pop;
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (w_wd_next == WD_LIMIT);

    // Next outstanding count; simultaneous push and pop cancel out.
    always_comb begin
        w_outstanding_next = r_outstanding;
        case ({w_push, w_pop})
            2'b10:   w_outstanding_next = r_outstanding + OCC_W'(1);
            2'b01:   w_outstanding_next = r_outstanding - OCC_W'(1);
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    // Watchdog next value: zero when idle, on a handshake or on clear;
    // otherwise count up and hold at the limit.
    always_comb begin
        w_wd_next = r_wd_cnt;
        if (TIMEOUT_CYCLES == 0) begin
            w_wd_next = {WD_W{1'b0}};
        end else if (i_clear || !w_stall) begin
            w_wd_next = {WD_W{1'b0}};
        end else if (r_wd_cnt == WD_LIMIT) begin
            w_wd_next = r_wd_cnt;
        end else begin
            w_wd_next = r_wd_cnt + WD_W'(1);
        end
    end

    // Expected-ID FIFO storage and pointers; pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= {ID_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_issue_id;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy count and registered bready.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_outstanding <= {OCC_W{1'b0}};
            r_bready      <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_bready      <= (w_outstanding_next != {OCC_W{1'b0}});
        end
    end

    // Completion outputs: valid and mismatch pulse, data held until next completion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_done_valid  <= 1'b0;
            r_done_id     <= {ID_W{1'b0}};
            r_done_resp   <= 2'b00;
            r_done_ok     <= 1'b0;
            r_id_mismatch <= 1'b0;
        end else begin
            r_done_valid  <= w_pop;
            r_id_mismatch <= w_pop && w_mismatch;
            if (w_pop) begin
                r_done_id   <= w_head;
                r_done_resp <= i_bresp;
                r_done_ok   <= w_resp_ok;
            end
        end
    end

    // Saturating error counter; clear takes priority over an increment.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_err_count <= {CNT_W{1'b0}};
        end else if (w_pop && !w_resp_ok && !w_err_sat) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    // Watchdog counter and sticky timeout flag; clear takes priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wd_cnt  <= {WD_W{1'b0}};
            r_timeout <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_next;
            if (i_clear) begin
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_issue_ready = w_issue_ready;
    assign o_bready      = r_bready;
    assign o_done_valid  = r_done_valid;
    assign o_done_id     = r_done_id;
    assign o_done_resp   = r_done_resp;
    assign o_done_ok     = r_done_ok;
    assign o_id_mismatch = r_id_mismatch;
    assign o_outstanding = r_outstanding;
    assign o_err_count   = r_err_count;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_b_resp_tracker.sv
// Scoreboard bench for b_resp_tracker: stimulus pushes the expected
// completion when it drives a B handshake; a monitor pops and compares on
// every done_valid. Small parameters (TIMEOUT_CYCLES=8, CNT_W=2) exercise
// the watchdog and err_count saturation quickly.
module tb_b_resp_tracker;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       ok;
        logic       mm;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic [3:0] issue_id;
    logic       issue_ready;
    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;
    logic [3:0] bid;
    logic       done_valid;
    logic [3:0] done_id;
    logic [1:0] done_resp;
    logic       done_ok;
    logic       id_mismatch;
    logic [2:0] outstanding;
    logic [1:0] err_count;
    logic       timeout;
    logic       clear;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    b_resp_tracker #(
        .ID_W(4), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8), .CNT_W(2)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_issue_valid(issue_valid), .i_issue_id(issue_id), .o_issue_ready(issue_ready),
        .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp), .i_bid(bid),
        .o_done_valid(done_valid), .o_done_id(done_id), .o_done_resp(done_resp),
        .o_done_ok(done_ok), .o_id_mismatch(id_mismatch),
        .o_outstanding(outstanding), .o_err_count(err_count),
        .o_timeout(timeout), .i_clear(clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] id);
        issue_valid = 1'b1;
        issue_id    = id;
        step();
        issue_valid = 1'b0;
    endtask

    // Drive one B beat and record the completion it must produce.
    task automatic respond(input logic [1:0] resp, input logic [3:0] b_id, input logic [3:0] exp_id);
        exp_t e;
        chk("bready_before_resp", int'(bready), 1);
        e.id   = exp_id;
        e.resp = resp;
        e.ok   = (resp[1] == 1'b0) && (b_id == exp_id);
        e.mm   = (b_id != exp_id);
        exp_q.push_back(e);
        bvalid = 1'b1;
        bresp  = resp;
        bid    = b_id;
        step();
        bvalid = 1'b0;
    endtask

    // Monitor: compare every completion against the scoreboard head.
    always @(negedge clk) begin
        if (done_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_fields", int'({done_id, done_resp, done_ok, id_mismatch}), int'(e));
            end
        end else begin
            chk("id_mismatch_idle", int'(id_mismatch), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_id = 4'd0;
        bvalid = 1'b0; bresp = 2'b00; bid = 4'd0; clear = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b0;
        // Reset values.
        chk("rst_bready", int'(bready), 0);
        chk("rst_issue_ready", int'(issue_ready), 1);
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_done", int'({done_valid, done_id, done_resp, done_ok}), 0);

        // Single write.
        issue(4'd3);
        chk("single_bready_up", int'(bready), 1);
        chk("single_outstanding", int'(outstanding), 1);
        step();
        respond(2'b00, 4'd3, 4'd3);
        chk("single_bready_down", int'(bready), 0);
        chk("single_outstanding_end", int'(outstanding), 0);

        // Fill, refused fifth issue, in-order drain.
        for (int i = 0; i < 4; i++) issue(4'(i));
        chk("fill_outstanding", int'(outstanding), 4);
        chk("fill_issue_ready", int'(issue_ready), 0);
        issue(4'd5);
        chk("fill_refused", int'(outstanding), 4);
        for (int i = 0; i < 4; i++) respond(2'b00, 4'(i), 4'(i));
        chk("fill_drained", int'(outstanding), 0);

        // Error responses and saturation at 3.
        issue(4'd5); issue(4'd6); issue(4'd7);
        respond(2'b10, 4'd5, 4'd5);
        respond(2'b11, 4'd6, 4'd6);
        respond(2'b00, 4'd9, 4'd7);
        chk("err_count_3", int'(err_count), 3);
        issue(4'd1);
        respond(2'b10, 4'd1, 4'd1);
        chk("err_count_sat", int'(err_count), 3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("err_count_cleared", int'(err_count), 0);

        // Simultaneous issue and response, first at full then at 2.
        for (int i = 8; i < 12; i++) issue(4'(i));
        begin
            exp_t e;
            e = {4'd8, 2'b00, 1'b1, 1'b0};
            exp_q.push_back(e);
        end
        issue_valid = 1'b1; issue_id = 4'd12;
        bvalid = 1'b1; bresp = 2'b00; bid = 4'd8;
        step();
        issue_valid = 1'b0; bvalid = 1'b0;
        chk("simul_full_outstanding", int'(outstanding), 3);
        respond(2'b00, 4'd9, 4'd9);
        chk("simul_two", int'(outstanding), 2);
        begin
            exp_t e;
            e = {4'd10, 2'b00, 1'b1, 1'b0};
            exp_q.push_back(e);
        end
        issue_valid = 1'b1; issue_id = 4'd13;
        bvalid = 1'b1; bresp = 2'b00; bid = 4'd10;
        step();
        issue_valid = 1'b0; bvalid = 1'b0;
        chk("simul_two_kept", int'(outstanding), 2);
        respond(2'b00, 4'd11, 4'd11);
        respond(2'b00, 4'd13, 4'd13);
        chk("simul_drained", int'(outstanding), 0);

        // Watchdog: timeout after 8 stall cycles, late response still accepted.
        issue(4'd4);
        repeat (7) step();
        chk("timeout_not_yet", int'(timeout), 0);
        step();
        chk("timeout_set", int'(timeout), 1);
        respond(2'b01, 4'd4, 4'd4);
        chk("timeout_sticky", int'(timeout), 1);
        step();
        chk("timeout_sticky2", int'(timeout), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("timeout_cleared", int'(timeout), 0);

        // Reset with three outstanding writes.
        issue(4'd1); issue(4'd2); issue(4'd3);
        chk("pre_reset_outstanding", int'(outstanding), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_outstanding", int'(outstanding), 0);
        chk("mid_rst_bready", int'(bready), 0);
        chk("mid_rst_issue_ready", int'(issue_ready), 1);
        chk("mid_rst_done", int'({done_id, done_resp, done_ok}), 0);
        chk("mid_rst_timeout_err", int'({timeout, err_count}), 0);
        step();
        issue(4'd6);
        respond(2'b00, 4'd6, 4'd6);
        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
